usadd_epoch_ctrl: RTL and testbench

- Sequences one unipolar scaled stochastic adder (uSADD_uni) through complete addition epochs.
- Accepts two binary operands over a valid/ready handshake, clears the adder, and drives it with two decorrelated unary bitstreams of length 2^BITWIDTH.
- Counts the adder's output ones, then returns the binary scaled sum floor((A+B)/2) over a second valid/ready handshake.
- Sits between a binary host/datapath and the stochastic adder, and is the only agent that resets or feeds it.

---
 rtl/usadd_epoch_ctrl.sv | 136 +++++++++++++
 tb/tb_usadd_epoch_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/usadd_epoch_ctrl.sv
// Epoch controller for a unipolar scaled stochastic adder: takes two binary
// operands, streams them as decorrelated unary bitstreams, counts the ones.
module usadd_epoch_ctrl #(
  parameter int BITWIDTH = 8,
  parameter int ADD_LAT  = 2
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iOpA,
  input  logic [BITWIDTH-1:0] iOpB,
  output logic                oA,
  output logic                oB,
  output logic                oAddRstN,
  input  logic                iC,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oResult,
  output logic                oBusy
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [BITWIDTH-1:0] CNT_LAST   = '1;
  localparam logic [BITWIDTH-1:0] DRAIN_LAST = BITWIDTH'(ADD_LAT > 0 ? ADD_LAT - 1 : 0);
  localparam logic [BITWIDTH:0]   ACC_MAX    = '1;
  localparam logic [BITWIDTH:0]   RES_MAX    = {1'b0, {BITWIDTH{1'b1}}};

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] cnt_q, cnt_d;
  logic [BITWIDTH-1:0] opa_q, opa_d;
  logic [BITWIDTH-1:0] opb_q, opb_d;
  logic [BITWIDTH-1:0] result_q, result_d;
  logic [BITWIDTH:0]   acc_q, acc_d;
  logic [BITWIDTH-1:0] cnt_rev;

  function automatic logic [BITWIDTH-1:0] sat(input logic [BITWIDTH:0] v);
    return (v > RES_MAX) ? {BITWIDTH{1'b1}} : v[BITWIDTH-1:0];
  endfunction

  // Bit-reversed counter drives stream B so it is decorrelated from the thermometer A.
  generate
    for (genvar gi = 0; gi < BITWIDTH; gi++) begin : g_rev
      assign cnt_rev[gi] = cnt_q[BITWIDTH-1-gi];
    end
  endgenerate

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    oReady   = 1'b0;
    oValid   = 1'b0;
    oBusy    = 1'b0;
    oAddRstN = 1'b0;
    oA       = 1'b0;
    oB       = 1'b0;

    // The counter sticks at its maximum rather than wrapping on a misbehaving adder.
    if ((state_q == S_RUN || state_q == S_DRAIN) && iC && acc_q != ACC_MAX)
      acc_d = acc_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        oReady = 1'b1;
        if (iValid) begin
          opa_d   = iOpA;
          opb_d   = iOpB;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        oBusy   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        oBusy    = 1'b1;
        oAddRstN = 1'b1;
        oA       = (cnt_q < opa_q);
        oB       = (cnt_rev < opb_q);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (ADD_LAT == 0) begin
            state_d  = S_DONE;
            result_d = sat(acc_d);
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        oBusy    = 1'b1;
        oAddRstN = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d    = '0;
          state_d  = S_DONE;
          result_d = sat(acc_d);
        end
      end
      S_DONE: begin
        oValid = 1'b1;
        if (iReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign oResult = result_q;

endmodule

// File: tb/tb_usadd_epoch_ctrl.sv
// Bench for usadd_epoch_ctrl driving a behavioural two-cycle-latency
// unipolar scaled stochastic adder.
module tb_usadd_epoch_ctrl;

  localparam int BW  = 8;
  localparam int LAT = 2;
  localparam int EPOCH_LAT = 1 + (1 << BW) + LAT;  // 259
  localparam int PERIOD    = (1 << BW) + LAT + 3;  // 261

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iValid;
  logic          oReady;
  logic [BW-1:0] iOpA, iOpB;
  logic          oA, oB, oAddRstN;
  logic          iC;
  logic          oValid;
  logic          iReady;
  logic [BW-1:0] oResult;
  logic          oBusy;

  usadd_epoch_ctrl #(.BITWIDTH(BW), .ADD_LAT(LAT)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
    .iOpA(iOpA), .iOpB(iOpB), .oA(oA), .oB(oB), .oAddRstN(oAddRstN),
    .iC(iC), .oValid(oValid), .iReady(iReady), .oResult(oResult), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  // Adder model: residue bit plus a two-stage output pipe.
  logic       add_p, add_s1, add_s2;
  logic [1:0] add_sum;
  assign add_sum = {1'b0, add_p} + {1'b0, oA} + {1'b0, oB};
  assign iC = add_s2;
  always @(posedge iClk or negedge oAddRstN) begin
    if (!oAddRstN) begin
      add_p  <= 1'b0;
      add_s1 <= 1'b0;
      add_s2 <= 1'b0;
    end else begin
      add_p  <= add_sum[0];
      add_s1 <= add_sum[1];
      add_s2 <= add_s1;
    end
  end

  // Stream monitor: ones on oA/oB during the busy window of an epoch.
  int mon_a, mon_b;
  always @(negedge iClk) begin
    if (oReady) begin
      mon_a <= 0;
      mon_b <= 0;
    end else if (oBusy) begin
      mon_a <= mon_a + int'(oA);
      mon_b <= mon_b + int'(oB);
    end
  end

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] exp;
  } vec_t;

  // One epoch; optional result stall with an ignored iValid pulse inside it.
  task automatic run_epoch(input logic [BW-1:0] a, input logic [BW-1:0] b,
                           input logic [BW-1:0] exp, input int stall);
    int lat;
    logic [BW-1:0] e;
    @(negedge iClk);
    iOpA = a; iOpB = b; iValid = 1'b1;
    chk("ready_idle", oReady, 1);
    @(posedge iClk);
    sb_q.push_back(exp);
    #1 iValid = 1'b0;
    lat = 0;
    while (!oValid && lat < 400) begin
      @(posedge iClk); #1;
      lat++;
    end
    chk("latency", lat, EPOCH_LAT);
    chk("ones_a", mon_a, a);
    chk("ones_b", mon_b, b);
    e = (sb_q.size() > 0) ? sb_q[0] : '0;
    for (int s = 0; s < stall; s++) begin
      @(negedge iClk);
      chk("stall_result", oResult, e);
      chk("stall_ready", oReady, 0);
      chk("stall_valid", oValid, 1);
      if (s == 5) begin
        iOpA = 8'd7; iOpB = 8'd9; iValid = 1'b1;
      end else begin
        iValid = 1'b0;
      end
    end
    iValid = 1'b0;
    iReady = 1'b1;
    @(negedge iClk);
    if (sb_q.size() == 0) chk("sb_empty", 1, 0);
    else chk("result", oResult, sb_q.pop_front());
    @(posedge iClk); #1;
    iReady = 1'b0;
    chk("valid_drop", oValid, 0);
    chk("ready_back", oReady, 1);
  endtask

  vec_t vecs[6];

  initial begin
    int cyc, accepts, results, last_acc;
    logic [BW-1:0] ra, rb;

    vecs[0] = '{a: 8'd0,   b: 8'd0,   exp: 8'd0};
    vecs[1] = '{a: 8'd255, b: 8'd255, exp: 8'd255};
    vecs[2] = '{a: 8'd100, b: 8'd51,  exp: 8'd75};
    vecs[3] = '{a: 8'd1,   b: 8'd0,   exp: 8'd0};
    vecs[4] = '{a: 8'd200, b: 8'd0,   exp: 8'd100};
    vecs[5] = '{a: 8'd13,  b: 8'd128, exp: 8'd70};

    iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iOpA = '0; iOpB = '0;
    #2;
    chk("rst_ready", oReady, 1);
    chk("rst_valid", oValid, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_addrstn", oAddRstN, 0);
    chk("rst_result", oResult, 0);
    repeat (2) @(negedge iClk);
    iRst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_epoch(vecs[i].a, vecs[i].b, vecs[i].exp, 0);
      $display("vec %0d: a=%0d b=%0d exp=%0d", i, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    run_epoch(8'd100, 8'd51, 8'd75, 20);
    $display("stall epoch: a=100 b=51 exp=75");
    run_epoch(8'd40, 8'd60, 8'd50, 0);
    $display("post-stall epoch: a=40 b=60 exp=50");

    // Reset during RUN with cnt=128.
    @(negedge iClk);
    iOpA = 8'd200; iOpB = 8'd99; iValid = 1'b1;
    @(posedge iClk); #1 iValid = 1'b0;
    repeat (129) @(posedge iClk);
    #1;
    chk("midrun_a", oA, 1);
    chk("midrun_b", oB, 1);
    iRst = 1'b1;
    #1;
    chk("mrst_valid", oValid, 0);
    chk("mrst_addrstn", oAddRstN, 0);
    chk("mrst_a", oA, 0);
    chk("mrst_b", oB, 0);
    chk("mrst_busy", oBusy, 0);
    chk("mrst_result", oResult, 0);
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    run_epoch(8'd10, 8'd30, 8'd20, 0);
    $display("post-reset epoch: a=10 b=30 exp=20");

    // Back-to-back epochs with iValid and iReady held high.
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    iOpA = ra; iOpB = rb; iValid = 1'b1; iReady = 1'b1;
    cyc = 0; accepts = 0; results = 0; last_acc = 0;
    while (results < 4 && cyc < 1500) begin
      @(negedge iClk);
      cyc++;
      if (oValid) begin
        if (sb_q.size() == 0) chk("b2b_sb_empty", 1, 0);
        else chk("b2b_result", oResult, sb_q.pop_front());
        results++;
      end
      if (oReady && accepts < 4) begin
        sb_q.push_back(8'((9'(ra) + 9'(rb)) >> 1));
        $display("b2b accept %0d: a=%0d b=%0d exp=%0d", accepts, ra, rb, (int'(ra) + int'(rb)) / 2);
        if (accepts > 0) chk("b2b_spacing", cyc - last_acc, PERIOD);
        last_acc = cyc;
        accepts++;
        @(posedge iClk); #1;
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        iOpA = ra; iOpB = rb;
        if (accepts == 4) iValid = 1'b0;
      end
    end
    chk("b2b_count", results, 4);
    iValid = 1'b0; iReady = 1'b0;
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
